// File: rtl/config_loader.sv
// Writer end of the CRAM configuration shift chain: accepts bitstream words and shifts exactly
// CHAIN_LEN bits MSB-first into the chain. Define CFG_READBACK_EN for a CRC-8 recirculating readback check.
module config_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 320
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_data_in,
    output logic              config_en,
    input  logic              config_data_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned REM_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
`ifdef CFG_READBACK_EN
        VERIFY,
`endif
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   bits_sent_q, bits_sent_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [31:0]        left_c;

    logic word_ready_q, word_ready_d;
    logic config_en_q, config_en_d;
    logic shift_bit_q, shift_bit_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

`ifdef CFG_READBACK_EN
    logic [7:0] crc_tx_q, crc_tx_d;
    logic [7:0] crc_rx_q, crc_rx_d;
    logic       error_q, error_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // Bits still owed to the chain; the final word may be truncated to this many bits.
    assign left_c = 32'(CHAIN_LEN) - 32'(bits_sent_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bits_sent_q  <= '0;
            rem_q        <= '0;
            word_ready_q <= 1'b0;
            config_en_q  <= 1'b0;
            shift_bit_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CFG_READBACK_EN
            crc_tx_q     <= '0;
            crc_rx_q     <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bits_sent_q  <= bits_sent_d;
            rem_q        <= rem_d;
            word_ready_q <= word_ready_d;
            config_en_q  <= config_en_d;
            shift_bit_q  <= shift_bit_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef CFG_READBACK_EN
            crc_tx_q     <= crc_tx_d;
            crc_rx_q     <= crc_rx_d;
            error_q      <= error_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_sent_d = bits_sent_q;
        rem_d       = rem_q;
`ifdef CFG_READBACK_EN
        crc_tx_d    = crc_tx_q;
        crc_rx_d    = crc_rx_q;
        error_d     = error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    bits_sent_d = '0;
`ifdef CFG_READBACK_EN
                    crc_tx_d    = '0;
                    crc_rx_d    = '0;
                    error_d     = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (word_valid && word_ready_q) begin
                    shreg_d = word_data;
                    rem_d   = (left_c >= 32'(WORD_W)) ? REM_W'(WORD_W) : REM_W'(left_c);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d     = shreg_q << 1;
                bits_sent_d = bits_sent_q + CNT_W'(1);
                rem_d       = rem_q - REM_W'(1);
`ifdef CFG_READBACK_EN
                crc_tx_d    = crc8_step(crc_tx_q, shreg_q[WORD_W-1]);
`endif
                if (rem_q == REM_W'(1)) begin
                    if (bits_sent_q == CNT_W'(CHAIN_LEN - 1)) begin
`ifdef CFG_READBACK_EN
                        state_d     = VERIFY;
                        bits_sent_d = '0;
`else
                        state_d     = DONE;
`endif
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
`ifdef CFG_READBACK_EN
            // Recirculate the whole chain once, checking what comes out of the tail.
            VERIFY: begin
                crc_rx_d    = crc8_step(crc_rx_q, config_data_out);
                bits_sent_d = bits_sent_q + CNT_W'(1);
                if (bits_sent_q == CNT_W'(CHAIN_LEN - 1)) begin
                    state_d = DONE;
                    error_d = (crc_rx_d != crc_tx_q);
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        word_ready_d = (state_d == LOAD);
`ifdef CFG_READBACK_EN
        config_en_d  = (state_d == SHIFT) || (state_d == VERIFY);
`else
        config_en_d  = (state_d == SHIFT);
`endif
        shift_bit_d  = (state_d == SHIFT) && shreg_d[WORD_W-1];
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    assign word_ready = word_ready_q;
    assign config_en  = config_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef CFG_READBACK_EN
    // Readback must loop the tail straight back to the head, so this path bypasses the output register.
    assign config_data_in = (state_q == VERIFY) ? config_data_out : shift_bit_q;
    assign error          = error_q;
`else
    logic unused_tail;
    assign unused_tail    = config_data_out;
    assign config_data_in = shift_bit_q;
    assign error          = 1'b0;
`endif

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Writer end of the CRAM configuration shift chain formed by daisy-chained logic elements.
- Accepts bitstream words over a valid/ready interface and serialises them MSB-first onto the chain head (config_data_in) with config_en.
- Counts exactly CHAIN_LEN shifts, then releases the chain and reports completion.
- Sits between the bitstream source (SPI/JTAG front end) and the fabric's first LE.

Parameters:
- WORD_W, 8: width of each input bitstream word.
- CHAIN_LEN, 320: total chain length in bits (e.g. 16 LEs x 20 bits).
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter (derived; do not override).

Ports:
- clk  input  1  fabric configuration clock; the fabric LEs' clk and this block share it.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- word_data  input  WORD_W  bitstream word, MSB shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  block accepts word_data this cycle.
- config_data_in  output  1  serial bit to chain head.
- config_en  output  1  shift strobe to chain; LE en is tied high at top level.
- config_data_out  input  1  chain tail; used only with CFG_READBACK_EN.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when load (and verify, if compiled in) completes.
- error  output  1  readback CRC mismatch; sticky until next accepted start; tied 0 without CFG_READBACK_EN.

Behaviour:
- Reset: one clock, and it dominates all other inputs. All outputs are 0 on the following edge. State goes to IDLE; counters and the shift register clear. A reset mid-load abandons the load immediately. The chain keeps its partial contents; no extra shifts are issued.
- FSM states: IDLE, LOAD, SHIFT, VERIFY (only with CFG_READBACK_EN), DONE.
- IDLE: start=1 -> LOAD. The bit counter clears and error clears. A start while busy is ignored.
- LOAD: word_ready=1 and config_en=0.
  - When word_valid && word_ready, latch word_data into the shift register, set the bit-in-word count to min(WORD_W, CHAIN_LEN - bits_sent), and go to SHIFT.
  - With no valid word, LOAD waits indefinitely.
- SHIFT: word_ready=0. Each cycle: config_en=1, config_data_in = shreg[WORD_W-1], shreg shifts left, bits_sent increments.
  - Last bit of the word with bits_sent reaching CHAIN_LEN -> VERIFY, or DONE if the feature is not compiled in.
  - Last bit of the word otherwise -> LOAD.
- Partial final word: when CHAIN_LEN is not a multiple of WORD_W, only the upper (CHAIN_LEN mod WORD_W) bits of the last word are shifted. The lower bits are discarded.
- Throughput: one word per WORD_W+1 cycles (1 accept cycle plus WORD_W shift cycles).
- config_en is high only in cycles that present a valid bit. No shift ever occurs outside SHIFT/VERIFY. Exactly CHAIN_LEN shifts occur per load (2*CHAIN_LEN with verify).
- config_data_in is 0 whenever config_en=0.
- DONE: done=1 and busy=1 for one cycle, then IDLE. Words offered after the final word are not accepted; word_ready stays 0 until the next start.
- Chain ordering: the first bit sent ends at the tail LE's config MSB. The chain is FIFO-ordered, so after CHAIN_LEN further shifts the bits emerge at config_data_out in send order.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined:
  - During SHIFT, a CRC-8 runs over every sent bit: polynomial 0x07, init 0x00, bit-serial, fb = crc[7]^bit, crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
  - After the last bit, enter VERIFY for exactly CHAIN_LEN cycles. In each cycle config_en=1 and config_data_in = config_data_out (non-destructive recirculation), and a second CRC-8 runs over config_data_out.
  - At the end of VERIFY, error is set if the two CRCs differ. Then go to DONE.
- Undefined: no VERIFY state and no CRC logic; error is tied 0 and config_data_out is unused.

Test Plan:
- Basic load. Stimulus: CHAIN_LEN=20, WORD_W=8, start, then words 0xA5, 0x3C, 0xF0 with word_valid always high. Response: serial stream 10100101 00111100 1111 on config_data_in; config_en high for exactly 20 cycles; 0xF0 low nibble dropped; done pulses once; total 23 cycles from first accept to DONE.
- Backpressure/gaps. Stimulus: word_valid deasserted for 5 cycles between words. Response: config_en stays 0 during the gap; the bit stream is identical to the basic load; word_ready is high only in LOAD.
- Reset mid-load. Stimulus: rst asserted after 10 shifts. Response: next edge gives config_en=0, busy=0, word_ready=0. A new start followed by a full load gives exactly 20 fresh shifts.
- Ignored start and extra words. Stimulus: start pulsed during SHIFT; a 4th word offered after the final word. Response: no restart; the 4th word is not accepted (word_ready=0); done pulses once.
- Readback pass (CFG_READBACK_EN). Stimulus: connect a 20-bit behavioural LE-chain model and run the basic load. Response: 20 further recirculating shifts; error=0; chain contents unchanged.
- Readback fail (CFG_READBACK_EN). Stimulus: force one chain bit flipped during VERIFY. Response: error=1 with the done pulse; error stays 1 until the next accepted start.
